fir_coeff_loader: RTL and testbench

- Host-side write/read interface for the 33-tap FIR filter's coefficient set; supplies the filter's parallel coefficient inputs and its per-sample accumulate enable.
- Host writes coefficients one at a time into a shadow bank, then requests a commit.
- The shadow bank is copied into the active bank, which drives the filter, only between sample strobes, so a filter computation never sees a mixed coefficient set.
- Sits between the control bus and the direct/transposed FIR datapaths.

---
 rtl/fir_coeff_loader.sv | 157 +++++++++++++++
 tb/tb_fir_coeff_loader.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_coeff_loader.sv
// Coefficient shadow/active bank manager for the 33-tap FIR filter.
// The host writes and reads a shadow bank. A commit copies the shadow bank
// into the active bank only in the cycle after a sample strobe, so the filter
// never sees a mixed coefficient set. This block also generates the per-sample
// accumulate strobe.
module fir_coeff_loader #(
   parameter int NUM_TAPS   = 33,
   parameter int COEFF_W    = 16,
   parameter int ADDR_W     = 6,
   parameter int SAMPLE_DIV = 12
) (
   input  logic                        iClk_12M,
   input  logic                        iRsn,
   input  logic                        iRun,
   input  logic                        iCsn,
   input  logic                        iWrEn,
   input  logic [ADDR_W-1:0]           iAddr,
   input  logic [COEFF_W-1:0]          iWrDt,
   output logic [COEFF_W-1:0]          oRdDt,
   output logic                        oRdValid,
   output logic                        oWrErr,
   input  logic                        iCommit,
   output logic                        oCommitBusy,
   output logic                        oEnAcc,
   output logic [NUM_TAPS*COEFF_W-1:0] oCoeffBus
);

   localparam int                CNT_W    = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(SAMPLE_DIV - 1);
   localparam logic [ADDR_W-1:0] ADDR_LIM = ADDR_W'(NUM_TAPS);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PEND = 2'd1,
      ST_COPY = 2'd2
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               en_acc_q, en_acc_d;
   logic [COEFF_W-1:0] rd_dt_q, rd_dt_d;
   logic               rd_valid_q, rd_valid_d;
   logic               wr_err_q, wr_err_d;
   logic [COEFF_W-1:0] shadow_q [NUM_TAPS];
   logic [COEFF_W-1:0] active_q [NUM_TAPS];
   logic [COEFF_W-1:0] rd_mux;
   logic               copy_en;
   logic               busy;
   logic               addr_ok;
   logic               wr_req;
   logic               rd_req;
   logic               wr_ok;

   assign busy    = (state_q != ST_IDLE);
   assign addr_ok = (iAddr < ADDR_LIM);
   assign wr_req  = ~iCsn & iWrEn;
   assign rd_req  = ~iCsn & ~iWrEn;
   assign wr_ok   = wr_req & addr_ok & ~busy;

   // Sample counter: wraps every SAMPLE_DIV cycles and raises the strobe on the wrap edge.
   always_comb begin
      cnt_d    = cnt_q;
      en_acc_d = 1'b0;
      if (!iRun) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         cnt_d    = '0;
         en_acc_d = 1'b1;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // Shadow read mux. An out-of-range address reads as zero.
   always_comb begin
      rd_mux = '0;
      for (int i = 0; i < NUM_TAPS; i++) begin
         if (iAddr == ADDR_W'(i)) rd_mux = shadow_q[i];
      end
   end

   // Host response: read data is held between reads; errors flag bad addresses and writes while busy.
   always_comb begin
      rd_dt_d    = rd_dt_q;
      rd_valid_d = rd_req;
      wr_err_d   = 1'b0;
      if (rd_req) begin
         rd_dt_d  = rd_mux;
         wr_err_d = ~addr_ok;
      end else if (wr_req) begin
         wr_err_d = ~addr_ok | busy;
      end
   end

   // Commit FSM: wait for the filter to consume a strobe, then copy every tap in one edge.
   always_comb begin
      state_d = state_q;
      copy_en = 1'b0;
      case (state_q)
         ST_IDLE: if (iCommit) state_d = ST_PEND;
         ST_PEND: if (en_acc_q || !iRun) state_d = ST_COPY;
         ST_COPY: begin
            copy_en = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Control registers. Reset abandons any commit in flight.
   always_ff @(posedge iClk_12M or negedge iRsn) begin
      if (!iRsn) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         en_acc_q   <= 1'b0;
         rd_dt_q    <= '0;
         rd_valid_q <= 1'b0;
         wr_err_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         en_acc_q   <= en_acc_d;
         rd_dt_q    <= rd_dt_d;
         rd_valid_q <= rd_valid_d;
         wr_err_q   <= wr_err_d;
      end
   end

   // Coefficient banks. A write to the shadow bank and a copy never overlap because writes are refused while busy.
   always_ff @(posedge iClk_12M or negedge iRsn) begin
      if (!iRsn) begin
         for (int i = 0; i < NUM_TAPS; i++) begin
            shadow_q[i] <= '0;
            active_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_TAPS; i++) begin
            if (wr_ok && (iAddr == ADDR_W'(i))) shadow_q[i] <= iWrDt;
            if (copy_en) active_q[i] <= shadow_q[i];
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_TAPS; gi++) begin : g_bus
         assign oCoeffBus[gi*COEFF_W +: COEFF_W] = active_q[gi];
      end
   endgenerate

   assign oRdDt       = rd_dt_q;
   assign oRdValid    = rd_valid_q;
   assign oWrErr      = wr_err_q;
   assign oCommitBusy = busy;
   assign oEnAcc      = en_acc_q;

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Testbench for fir_coeff_loader: directed scenarios plus randomized traffic
// checked against a behavioural model of the coefficient banks.
module tb_fir_coeff_loader;

   localparam int NT  = 33;
   localparam int CW  = 16;
   localparam int AW  = 6;
   localparam int DIV = 12;

   logic              clk    = 1'b0;
   logic              rst_n  = 1'b0;
   logic              run    = 1'b0;
   logic              csn    = 1'b1;
   logic              wren   = 1'b0;
   logic              commit = 1'b0;
   logic [AW-1:0]     addr   = '0;
   logic [CW-1:0]     wrdt   = '0;
   logic [CW-1:0]     rd_dt;
   logic              rd_valid;
   logic              wr_err;
   logic              busy;
   logic              en_acc;
   logic [NT*CW-1:0]  coeff;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fir_coeff_loader #(
      .NUM_TAPS  (NT),
      .COEFF_W   (CW),
      .ADDR_W    (AW),
      .SAMPLE_DIV(DIV)
   ) dut (
      .iClk_12M   (clk),
      .iRsn       (rst_n),
      .iRun       (run),
      .iCsn       (csn),
      .iWrEn      (wren),
      .iAddr      (addr),
      .iWrDt      (wrdt),
      .oRdDt      (rd_dt),
      .oRdValid   (rd_valid),
      .oWrErr     (wr_err),
      .iCommit    (commit),
      .oCommitBusy(busy),
      .oEnAcc     (en_acc),
      .oCoeffBus  (coeff)
   );

   // ---------------- behavioural reference model ----------------
   logic [CW-1:0]    m_shadow [NT];
   logic [CW-1:0]    m_active [NT];
   logic [CW-1:0]    m_rd;
   logic             m_rdv, m_err, m_en, m_pend, m_copy;
   int               m_run_edges;
   logic [NT*CW-1:0] m_flat;

   // Strobe: every DIV-th edge of an uninterrupted run. Commit: request, wait for a consumed strobe (or stopped run), copy.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NT; i++) begin
            m_shadow[i] <= '0;
            m_active[i] <= '0;
         end
         m_rd <= '0; m_rdv <= 1'b0; m_err <= 1'b0; m_en <= 1'b0;
         m_pend <= 1'b0; m_copy <= 1'b0; m_run_edges <= 0;
      end else begin
         m_run_edges <= run ? m_run_edges + 1 : 0;
         m_en        <= run && (((m_run_edges + 1) % DIV) == 0);
         m_rdv       <= 1'b0;
         m_err       <= 1'b0;
         if (!csn) begin
            if (wren) begin
               if ((int'(addr) < NT) && !(m_pend || m_copy)) m_shadow[addr] <= wrdt;
               else m_err <= 1'b1;
            end else begin
               m_rdv <= 1'b1;
               if (int'(addr) < NT) m_rd <= m_shadow[addr];
               else begin
                  m_rd  <= '0;
                  m_err <= 1'b1;
               end
            end
         end
         if (m_copy) begin
            for (int i = 0; i < NT; i++) m_active[i] <= m_shadow[i];
            m_copy <= 1'b0;
         end else if (m_pend) begin
            if (m_en || !run) begin
               m_pend <= 1'b0;
               m_copy <= 1'b1;
            end
         end else if (commit) begin
            m_pend <= 1'b1;
         end
      end
   end

   always_comb begin
      m_flat = '0;
      for (int i = 0; i < NT; i++) m_flat[i*CW +: CW] = m_active[i];
   end

   // ---------------- stimulus helpers ----------------
   // One host cycle: drive on the falling edge, return 1 time unit after the rising edge.
   task automatic drive(input logic cs, input logic we, input logic [AW-1:0] a,
                        input logic [CW-1:0] d, input logic cm);
      @(negedge clk);
      csn = ~cs; wren = we; addr = a; wrdt = d; commit = cm;
      @(posedge clk);
      #1;
      csn = 1'b1; wren = 1'b0; commit = 1'b0;
   endtask

   task automatic idle_cycle();
      @(posedge clk);
      #1;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1;
      checks++; if (en_acc !== 1'b0)   begin errors++; $display("FAIL reset_en_acc: got %b expected 0", en_acc); end
      checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
      checks++; if (wr_err !== 1'b0)   begin errors++; $display("FAIL reset_wr_err: got %b expected 0", wr_err); end
      checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
      checks++; if (rd_dt !== 16'h0)   begin errors++; $display("FAIL reset_rd_dt: got %h expected 0", rd_dt); end
      checks++; if (coeff !== '0)      begin errors++; $display("FAIL reset_coeff: got nonzero bus expected 0"); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_strobe();
      logic exp_en;
      @(negedge clk);
      run = 1'b1;
      for (int cyc = 1; cyc <= 3 * DIV; cyc++) begin
         idle_cycle();
         exp_en = ((cyc % DIV) == 0);
         checks++;
         if (en_acc !== exp_en) begin
            errors++; $display("FAIL strobe_cycle_%0d: got %b expected %b", cyc, en_acc, exp_en);
         end
         checks++;
         if (coeff !== '0) begin errors++; $display("FAIL strobe_coeff_cycle_%0d: got nonzero bus expected 0", cyc); end
      end
   endtask

   task automatic test_write_read();
      drive(1'b1, 1'b1, 6'd0, 16'h0123, 1'b0);
      checks++; if (wr_err !== 1'b0) begin errors++; $display("FAIL wr0_err: got %b expected 0", wr_err); end
      drive(1'b1, 1'b1, 6'd32, 16'hFFF0, 1'b0);
      checks++; if (wr_err !== 1'b0) begin errors++; $display("FAIL wr32_err: got %b expected 0", wr_err); end
      drive(1'b1, 1'b0, 6'd0, 16'h0, 1'b0);
      checks++; if (rd_dt !== 16'h0123) begin errors++; $display("FAIL rd0_data: got %h expected 0123", rd_dt); end
      checks++; if (rd_valid !== 1'b1)  begin errors++; $display("FAIL rd0_valid: got %b expected 1", rd_valid); end
      drive(1'b1, 1'b0, 6'd32, 16'h0, 1'b0);
      checks++; if (rd_dt !== 16'hFFF0) begin errors++; $display("FAIL rd32_data: got %h expected fff0", rd_dt); end
      checks++; if (rd_valid !== 1'b1)  begin errors++; $display("FAIL rd32_valid: got %b expected 1", rd_valid); end
      idle_cycle();
      checks++; if (rd_valid !== 1'b0)  begin errors++; $display("FAIL rd_valid_drop: got %b expected 0", rd_valid); end
      checks++; if (rd_dt !== 16'hFFF0) begin errors++; $display("FAIL rd_hold: got %h expected fff0", rd_dt); end
      checks++; if (coeff !== '0)       begin errors++; $display("FAIL no_commit_coeff: got nonzero bus expected 0"); end
   endtask

   task automatic test_commit();
      bit found;
      found = 0;
      for (int k = 0; k < 2 * DIV && !found; k++) begin
         idle_cycle();
         if (en_acc === 1'b1) found = 1;
      end
      checks++; if (!found) begin errors++; $display("FAIL commit_find_strobe: got none expected strobe"); end
      idle_cycle();
      idle_cycle();
      drive(1'b0, 1'b0, 6'd0, 16'h0, 1'b1);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL commit_busy_start: got %b expected 1", busy); end
      drive(1'b1, 1'b1, 6'd1, 16'hBEEF, 1'b0);
      checks++; if (wr_err !== 1'b1) begin errors++; $display("FAIL busy_write_err: got %b expected 1", wr_err); end
      found = 0;
      for (int k = 0; k < 2 * DIV && !found; k++) begin
         idle_cycle();
         if (en_acc === 1'b1) found = 1;
      end
      checks++; if (!found) begin errors++; $display("FAIL commit_next_strobe: got none expected strobe"); end
      checks++; if (busy !== 1'b1)         begin errors++; $display("FAIL commit_busy_at_strobe: got %b expected 1", busy); end
      checks++; if (coeff[15:0] !== 16'h0) begin errors++; $display("FAIL commit_old_at_strobe: got %h expected 0", coeff[15:0]); end
      idle_cycle();
      checks++; if (busy !== 1'b1)         begin errors++; $display("FAIL commit_busy_copy: got %b expected 1", busy); end
      checks++; if (coeff[15:0] !== 16'h0) begin errors++; $display("FAIL commit_old_after_strobe: got %h expected 0", coeff[15:0]); end
      idle_cycle();
      checks++; if (busy !== 1'b0)              begin errors++; $display("FAIL commit_busy_end: got %b expected 0", busy); end
      checks++; if (coeff[15:0] !== 16'h0123)   begin errors++; $display("FAIL commit_tap1: got %h expected 0123", coeff[15:0]); end
      checks++; if (coeff[31:16] !== 16'h0)     begin errors++; $display("FAIL commit_tap2: got %h expected 0", coeff[31:16]); end
      checks++; if (coeff[527:512] !== 16'hFFF0) begin errors++; $display("FAIL commit_tap33: got %h expected fff0", coeff[527:512]); end
      found = 0;
      for (int k = 0; k < 2 * DIV && !found; k++) begin
         idle_cycle();
         if (en_acc === 1'b1) found = 1;
      end
      checks++; if (!found || coeff[15:0] !== 16'h0123) begin
         errors++; $display("FAIL commit_hold: got %h strobe %0d expected 0123 strobe 1", coeff[15:0], found);
      end
      drive(1'b1, 1'b0, 6'd1, 16'h0, 1'b0);
      checks++; if (rd_dt !== 16'h0) begin errors++; $display("FAIL busy_write_ignored: got %h expected 0", rd_dt); end
   endtask

   task automatic test_bad_addr();
      drive(1'b1, 1'b1, 6'd33, 16'h5555, 1'b0);
      checks++; if (wr_err !== 1'b1) begin errors++; $display("FAIL wr33_err: got %b expected 1", wr_err); end
      drive(1'b1, 1'b1, 6'd63, 16'hAAAA, 1'b0);
      checks++; if (wr_err !== 1'b1) begin errors++; $display("FAIL wr63_err: got %b expected 1", wr_err); end
      drive(1'b1, 1'b0, 6'd33, 16'h0, 1'b0);
      checks++; if (rd_dt !== 16'h0)   begin errors++; $display("FAIL rd33_data: got %h expected 0", rd_dt); end
      checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL rd33_valid: got %b expected 1", rd_valid); end
      checks++; if (wr_err !== 1'b1)   begin errors++; $display("FAIL rd33_err: got %b expected 1", wr_err); end
      drive(1'b1, 1'b0, 6'd0, 16'h0, 1'b0);
      checks++; if (rd_dt !== 16'h0123) begin errors++; $display("FAIL bad_keep0: got %h expected 0123", rd_dt); end
      checks++; if (wr_err !== 1'b0)    begin errors++; $display("FAIL good_rd_err: got %b expected 0", wr_err); end
      drive(1'b1, 1'b0, 6'd32, 16'h0, 1'b0);
      checks++; if (rd_dt !== 16'hFFF0) begin errors++; $display("FAIL bad_keep32: got %h expected fff0", rd_dt); end
   endtask

   task automatic test_norun_commit();
      @(negedge clk);
      run = 1'b0;
      idle_cycle();
      idle_cycle();
      drive(1'b1, 1'b1, 6'd5, 16'h7FFF, 1'b1);
      checks++; if (busy !== 1'b1 || en_acc !== 1'b0) begin
         errors++; $display("FAIL norun_pend: got busy %b en %b expected busy 1 en 0", busy, en_acc);
      end
      idle_cycle();
      checks++; if (coeff[95:80] !== 16'h0 || en_acc !== 1'b0) begin
         errors++; $display("FAIL norun_early: got %h en %b expected 0000 en 0", coeff[95:80], en_acc);
      end
      idle_cycle();
      checks++; if (coeff[95:80] !== 16'h7FFF) begin errors++; $display("FAIL norun_tap6: got %h expected 7fff", coeff[95:80]); end
      checks++; if (busy !== 1'b0 || en_acc !== 1'b0) begin
         errors++; $display("FAIL norun_done: got busy %b en %b expected 0 0", busy, en_acc);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         if ($urandom_range(0, 19) == 0) run = ~run;
         csn    = ($urandom_range(0, 2) == 0);
         wren   = 1'($urandom_range(0, 1));
         addr   = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(33, 63)) : AW'($urandom_range(0, 32));
         wrdt   = CW'($urandom);
         commit = ($urandom_range(0, 9) == 0);
         @(posedge clk);
         #1;
         checks++; if (en_acc !== m_en)     begin errors++; $display("FAIL rnd_en_acc[%0d]: got %b expected %b", n, en_acc, m_en); end
         checks++; if (busy !== (m_pend | m_copy)) begin errors++; $display("FAIL rnd_busy[%0d]: got %b expected %b", n, busy, m_pend | m_copy); end
         checks++; if (rd_valid !== m_rdv)  begin errors++; $display("FAIL rnd_rd_valid[%0d]: got %b expected %b", n, rd_valid, m_rdv); end
         checks++; if (wr_err !== m_err)    begin errors++; $display("FAIL rnd_wr_err[%0d]: got %b expected %b", n, wr_err, m_err); end
         checks++; if (rd_dt !== m_rd)      begin errors++; $display("FAIL rnd_rd_dt[%0d]: got %h expected %h", n, rd_dt, m_rd); end
         checks++; if (coeff !== m_flat)    begin errors++; $display("FAIL rnd_coeff[%0d]: active bank differs from model", n); end
      end
      csn = 1'b1; commit = 1'b0;
   endtask

   task automatic test_reset_pend();
      bit idle_seen;
      @(negedge clk);
      run = 1'b1;
      idle_seen = 0;
      for (int k = 0; k < 4 * DIV && !idle_seen; k++) begin
         idle_cycle();
         if (busy === 1'b0) idle_seen = 1;
      end
      checks++; if (!idle_seen) begin errors++; $display("FAIL rst_wait_idle: got busy expected idle"); end
      drive(1'b1, 1'b1, 6'd0, 16'h4321, 1'b1);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_pend_busy: got %b expected 1", busy); end
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL rst_async_busy: got %b expected 0", busy); end
      checks++; if (coeff !== '0)   begin errors++; $display("FAIL rst_async_coeff: got nonzero bus expected 0"); end
      checks++; if (en_acc !== 1'b0) begin errors++; $display("FAIL rst_async_en: got %b expected 0", en_acc); end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b1, 1'b0, 6'd0, 16'h0, 1'b0);
      checks++; if (rd_dt !== 16'h0 || rd_valid !== 1'b1) begin
         errors++; $display("FAIL rst_read0: got %h valid %b expected 0000 valid 1", rd_dt, rd_valid);
      end
   endtask

   initial begin
      test_reset();
      test_strobe();
      test_write_read();
      test_commit();
      test_bad_addr();
      test_norun_commit();
      test_random();
      test_reset_pend();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
